new_usb_frame_scheduler: RTL and testbench

OHCI frame timing controller for the NewUSB host. It maintains FmRemaining, FrameNumber and the FrameRemainingToggle, and issues one Start-of-Frame request per frame to the packet engine. It generates the periodic/nonperiodic phase signal (frame_periodic) that sequences the list service between control/bulk and periodic list processing. It runs in the SoC clock domain and is advanced by a one-cycle bit-time tick from the PHY-side timing logic.

---
 rtl/new_usb_frame_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_new_usb_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/new_usb_frame_scheduler.sv
// rtl/new_usb_frame_scheduler.sv - OHCI frame timer: FmRemaining, FrameNumber, SOF requests, periodic phase.
// Optional scheduling-overrun reporting is enabled by defining NEWUSB_FRAME_OVERRUN_EN.
module new_usb_frame_scheduler #(
  parameter int FiWidth = 14,
  parameter int FnWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               tick_i,
  input  logic [FiWidth-1:0] fi_i,
  input  logic               fit_i,
  input  logic [FiWidth-1:0] ps_i,
  input  logic               ple_i,
  input  logic               periodic_done_i,
  output logic               sof_valid_o,
  input  logic               sof_ready_i,
  output logic [FnWidth-1:0] frame_number_o,
  output logic [FiWidth-1:0] fm_remaining_o,
  output logic               frt_o,
  output logic               frame_periodic_o,
  output logic               sf_o,
  output logic               fno_o,
  output logic               so_o,
  output logic [1:0]         so_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOF   = 2'd1,
    ST_FRAME = 2'd2
  } state_e;

  localparam logic [FiWidth-1:0] FiOne = FiWidth'(1);
  localparam logic [FnWidth-1:0] FnOne = FnWidth'(1);

  state_e             state_q, state_d;
  logic [FiWidth-1:0] fm_remaining_q, fm_remaining_d;
  logic [FnWidth-1:0] frame_number_q, frame_number_d;
  logic               frt_q, frt_d;
  logic               frame_periodic_q, frame_periodic_d;
  logic               sf_q, sf_d;
  logic               fno_q, fno_d;
  logic               first_frame_q, first_frame_d;
  logic               periodic_served_q, periodic_served_d;
  logic               handshake;
  logic               frame_end;
  logic               periodic_set;
  logic               periodic_clr;

  always_comb begin
    handshake = (state_q == ST_SOF) && start_i && sof_ready_i;
    frame_end = (state_q == ST_FRAME) && start_i && tick_i && (fm_remaining_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!start_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_SOF;
        ST_SOF:   if (sof_ready_i) state_d = ST_FRAME;
        ST_FRAME: if (frame_end) state_d = ST_SOF;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sof_valid_o      = (state_q == ST_SOF);
    frame_number_o   = frame_number_q;
    fm_remaining_o   = fm_remaining_q;
    frt_o            = frt_q;
    frame_periodic_o = frame_periodic_q;
    sf_o             = sf_q;
    fno_o            = fno_q;
  end

  always_comb begin
    fm_remaining_d    = fm_remaining_q;
    frame_number_d    = frame_number_q;
    frt_d             = frt_q;
    first_frame_d     = first_frame_q;
    sf_d              = 1'b0;
    fno_d             = 1'b0;

    if (!start_i) begin
      first_frame_d = 1'b1;
    end
    if (state_d == ST_IDLE) begin
      fm_remaining_d = '0;
    end

    // The first SOF after going operational reports the retained FN unchanged.
    if (handshake) begin
      fm_remaining_d = fi_i;
      frt_d          = fit_i;
      sf_d           = 1'b1;
      first_frame_d  = 1'b0;
      if (!first_frame_q) begin
        frame_number_d = frame_number_q + FnOne;
      end
      fno_d = frame_number_d[FnWidth-1] ^ frame_number_q[FnWidth-1];
    end else if ((state_q == ST_FRAME) && start_i && tick_i && (fm_remaining_q != '0)) begin
      fm_remaining_d = fm_remaining_q - FiOne;
    end

    periodic_served_d = periodic_served_q;
    if (handshake) begin
      periodic_served_d = 1'b0;
    end else if (periodic_done_i) begin
      periodic_served_d = 1'b1;
    end

    // Clear has priority over set, so a done pulse always closes the window.
    periodic_set = (state_q == ST_FRAME) && ple_i && !periodic_served_q &&
                   (fm_remaining_q <= ps_i);
    periodic_clr = periodic_done_i || !ple_i || (state_d != ST_FRAME);
    if (periodic_clr) begin
      frame_periodic_d = 1'b0;
    end else if (periodic_set) begin
      frame_periodic_d = 1'b1;
    end else begin
      frame_periodic_d = frame_periodic_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fm_remaining_q    <= '0;
      frame_number_q    <= '0;
      frt_q             <= 1'b0;
      frame_periodic_q  <= 1'b0;
      sf_q              <= 1'b0;
      fno_q             <= 1'b0;
      first_frame_q     <= 1'b1;
      periodic_served_q <= 1'b0;
    end else begin
      fm_remaining_q    <= fm_remaining_d;
      frame_number_q    <= frame_number_d;
      frt_q             <= frt_d;
      frame_periodic_q  <= frame_periodic_d;
      sf_q              <= sf_d;
      fno_q             <= fno_d;
      first_frame_q     <= first_frame_d;
      periodic_served_q <= periodic_served_d;
    end
  end

`ifdef NEWUSB_FRAME_OVERRUN_EN
  logic       so_q, so_d;
  logic [1:0] so_count_q, so_count_d;

  // A frame that ends while still in the periodic phase is an overrun.
  always_comb begin
    so_d       = frame_end && frame_periodic_q && !periodic_done_i;
    so_count_d = so_count_q + {1'b0, so_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      so_q       <= 1'b0;
      so_count_q <= 2'b00;
    end else begin
      so_q       <= so_d;
      so_count_q <= so_count_d;
    end
  end

  always_comb begin
    so_o       = so_q;
    so_count_o = so_count_q;
  end
`else
  always_comb begin
    so_o       = 1'b0;
    so_count_o = 2'b00;
  end
`endif

endmodule

// File: tb/tb_new_usb_frame_scheduler.sv
// tb/tb_new_usb_frame_scheduler.sv - directed bench with a behavioural frame-timer model checked every cycle.
module tb_new_usb_frame_scheduler;
  localparam int FI_W = 14;
  localparam int FN_W = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start, tick, fit, ple, done, ready;
  logic [FI_W-1:0] fi, ps;
  logic            sof_valid, frt, fp, sf, fno, so;
  logic [FN_W-1:0] fn;
  logic [FI_W-1:0] rem;
  logic [1:0]      soc;

  int checks = 0;
  int errors = 0;

  new_usb_frame_scheduler #(.FiWidth(FI_W), .FnWidth(FN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick),
    .fi_i(fi), .fit_i(fit), .ps_i(ps), .ple_i(ple),
    .periodic_done_i(done), .sof_valid_o(sof_valid), .sof_ready_i(ready),
    .frame_number_o(fn), .fm_remaining_o(rem), .frt_o(frt),
    .frame_periodic_o(fp), .sf_o(sf), .fno_o(fno), .so_o(so), .so_count_o(soc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for SOF acceptance, 2 inside a frame.
  int m_phase, m_rem, m_fn, m_soc, m_nfn;
  bit m_frt, m_fp, m_sf, m_fno, m_so, m_first, m_served, m_ending;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_rem = 0; m_fn = 0; m_soc = 0;
      m_frt = 0; m_fp = 0; m_sf = 0; m_fno = 0; m_so = 0;
      m_first = 1; m_served = 0;
    end else begin
      m_sf = 0; m_fno = 0; m_so = 0;
      if (!start) begin
        m_phase = 0; m_rem = 0; m_fp = 0; m_first = 1;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (ready) begin
          m_nfn = m_first ? m_fn : (m_fn + 1) % (1 << FN_W);
          m_fno = ((m_nfn >> (FN_W - 1)) & 1) != ((m_fn >> (FN_W - 1)) & 1);
          m_fn = m_nfn; m_first = 0; m_rem = int'(fi); m_frt = fit;
          m_served = 0; m_sf = 1; m_phase = 2;
        end
      end else begin
        m_ending = tick && (m_rem == 0);
`ifdef NEWUSB_FRAME_OVERRUN_EN
        if (m_ending && m_fp && !done) begin
          m_so = 1;
          m_soc = (m_soc + 1) % 4;
        end
`endif
        if (done || m_ending || !ple) m_fp = 0;
        else if (!m_served && m_rem <= int'(ps)) m_fp = 1;
        if (done) m_served = 1;
        if (m_ending) m_phase = 1;
        else if (tick) m_rem = m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (sof_valid !== (m_phase == 1) || fn !== FN_W'(m_fn) || rem !== FI_W'(m_rem) ||
        frt !== m_frt || fp !== m_fp || sf !== m_sf || fno !== m_fno ||
        so !== m_so || soc !== 2'(m_soc)) begin
      errors++;
      $display("FAIL model_cycle t=%0t dut sv=%b fn=%0d rem=%0d frt=%b fp=%b sf=%b fno=%b so=%b soc=%0d model sv=%b fn=%0d rem=%0d frt=%b fp=%b sf=%b fno=%b so=%b soc=%0d",
               $time, sof_valid, fn, rem, frt, fp, sf, fno, so, soc,
               (m_phase == 1), m_fn, m_rem, m_frt, m_fp, m_sf, m_fno, m_so, m_soc);
    end
  end

  initial begin
    int n;
    int bad;
    int fp_seen;
    int so_seen;
    int soc_log[4];
    logic [FN_W-1:0] fn_keep;

    start = 0; tick = 0; fi = 14'd11999; fit = 0; ps = '0; ple = 0; done = 0; ready = 1;
    soc_log = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("reset_sof_valid", sof_valid, 0);
    chk("reset_fn", fn, 0);
    chk("reset_rem", rem, 0);
    chk("reset_fp", fp, 0);
    rst = 0;
    @(negedge clk);

    // First frame after start keeps FN, then 12000 ticks to the next SOF.
    start = 1; fit = 1;
    @(negedge clk);
    chk("t1_sof_valid", sof_valid, 1);
    @(negedge clk);
    chk("t1_sf", sf, 1);
    chk("t1_fn0", fn, 0);
    chk("t1_rem", rem, 11999);
    chk("t1_frt", frt, 1);
    chk("t1_fno", fno, 0);
    tick = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!sf && n < 13000);
    chk("t1_frame_len", n, 12001);
    chk("t1_fn1", fn, 1);
    chk("t1_reload", rem, 11999);

    // Periodic window opens below PS and closes on done for the rest of the frame.
    ps = 14'd10800; ple = 1;
    n = 0;
    while (rem != 14'd10800 && n < 2000) begin @(negedge clk); n++; end
    chk("t2_fp_before", fp, 0);
    @(negedge clk);
    chk("t2_fp_rise", fp, 1);
    n = 0;
    while (rem != 14'd5000 && n < 7000) begin @(negedge clk); n++; end
    chk("t2_fp_at_5000", fp, 1);
    done = 1;
    @(negedge clk);
    done = 0;
    chk("t2_fp_clear", fp, 0);
    fp_seen = 0; n = 0;
    while (!sf && n < 6000) begin
      @(negedge clk); n++;
      if (fp) fp_seen++;
    end
    chk("t2_next_sof", sf, 1);
    chk("t2_fp_reopened", fp_seen, 0);

    // SOF held off by the packet engine: nothing advances until accepted.
    ple = 0; ready = 0; fi = 14'd3;
    n = 0;
    while (!sof_valid && n < 13000) begin @(negedge clk); n++; end
    chk("t3_sof_reached", sof_valid, 1);
    fn_keep = fn;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sof_valid !== 1'b1 || rem !== '0 || fn !== fn_keep) bad++;
    end
    chk("t3_hold_bad_cycles", bad, 0);
    ready = 1;
    @(negedge clk);
    chk("t3_sf", sf, 1);
    chk("t3_fn_inc", fn, fn_keep + 1);
    chk("t3_rem", rem, 3);
    chk("t3_fno", fno, 0);

    // Short frames up to the FN MSB crossing and the wrap.
    fi = '0;
    n = 0;
    while (fn != 12'h7FF && n < 20000) begin @(negedge clk); n++; end
    chk("t4_reach_7ff", fn, 12'h7FF);
    n = 0;
    do begin @(negedge clk); n++; end while (!sf && n < 20);
    chk("t4_fn_800", fn, 12'h800);
    chk("t4_fno_800", fno, 1);
    chk("t4_sf_800", sf, 1);
    n = 0;
    while (fn != 12'hFFF && n < 20000) begin @(negedge clk); n++; end
    chk("t4_reach_fff", fn, 12'hFFF);
    n = 0;
    do begin @(negedge clk); n++; end while (!sf && n < 20);
    chk("t4_fn_wrap", fn, 0);
    chk("t4_fno_wrap", fno, 1);

    // Periodic phase never completed: each frame end is an overrun.
    fi = 14'd3; ps = 14'd2; ple = 1;
    so_seen = 0; n = 0;
    while (so_seen < 4 && n < 60) begin
      @(negedge clk); n++;
      if (so) begin
        soc_log[so_seen] = int'(soc);
        so_seen++;
      end
    end
`ifdef NEWUSB_FRAME_OVERRUN_EN
    chk("t5_so_pulses", so_seen, 4);
    chk("t5_soc_1", soc_log[0], 1);
    chk("t5_soc_2", soc_log[1], 2);
    chk("t5_soc_3", soc_log[2], 3);
    chk("t5_soc_0", soc_log[3], 0);
`else
    chk("t5_so_pulses", so_seen, 0);
    chk("t5_soc", soc, 0);
`endif

    // Drop start mid periodic phase, then restart without an FN step.
    fi = 14'd20; ps = 14'd10;
    n = 0;
    do begin @(negedge clk); n++; end while (!sf && n < 40);
    n = 0;
    while (!fp && n < 40) begin @(negedge clk); n++; end
    chk("t6_fp_up", fp, 1);
    fn_keep = fn;
    start = 0;
    @(negedge clk);
    chk("t6_idle_sv", sof_valid, 0);
    chk("t6_idle_fp", fp, 0);
    chk("t6_idle_rem", rem, 0);
    chk("t6_idle_fn", fn, fn_keep);
    repeat (3) @(negedge clk);
    start = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!sf && n < 10);
    chk("t6_restart_sf", sf, 1);
    chk("t6_restart_fn", fn, fn_keep);
    n = 0;
    do begin @(negedge clk); n++; end while (!sf && n < 40);
    chk("t6_next_fn", fn, fn_keep + 1);

    // Asynchronous reset mid-frame.
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t7_fn", fn, 0);
    chk("t7_rem", rem, 0);
    chk("t7_sv", sof_valid, 0);
    chk("t7_soc", soc, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
